// File: rtl/regfile_fwd_multi.sv
// -----------------------------------------------------------------------------
// regfile_fwd_multi
//
// Purpose:
//   N-lane register file for a superscalar decode stage. Each lane has two
//   registered read ports with an EX/MEM forwarding select, one writeback
//   port, and an issue port. The issue port marks a destination register as
//   pending in a per-register busy scoreboard. The read ports report whether
//   each RF-sourced operand is still in flight, including RAW hazards on a
//   lower-numbered lane in the same issue bundle.
//
// Parameters:
//   LANES - number of issue/writeback lanes (1..4)
//   XLEN  - data width
//   NREG  - number of architectural registers; x0 is hardwired to zero
//   AW    - register address width, 2**AW >= NREG
//
// Ports (lane i of a packed bus occupies [i*W +: W]):
//   clk, rst                     clock (rising edge), async active-high reset
//   rd_en        [LANES]         read request
//   rs1_addr     [LANES*AW]      operand 1 address
//   rs2_addr     [LANES*AW]      operand 2 address
//   rs1_fwd_sel  [LANES*2]       00 RF, 01 EX, 10 MEM, 11 RF
//   rs2_fwd_sel  [LANES*2]       same encoding
//   rs1_ex_fwd   [LANES*XLEN]    EX forwarding data, operand 1
//   rs2_ex_fwd   [LANES*XLEN]    EX forwarding data, operand 2
//   rs1_mem_fwd  [LANES*XLEN]    MEM forwarding data, operand 1
//   rs2_mem_fwd  [LANES*XLEN]    MEM forwarding data, operand 2
//   issue_en     [LANES]         lane issues an instruction writing issue_rd
//   issue_rd     [LANES*AW]      destination of the issued instruction
//   wb_en        [LANES]         writeback strobe
//   wb_addr      [LANES*AW]      writeback address
//   wb_data      [LANES*XLEN]    writeback data
//   rs1_data     [LANES*XLEN]    registered operand 1
//   rs2_data     [LANES*XLEN]    registered operand 2
//   rd_valid     [LANES]         operands valid (one cycle after rd_en)
//   rs1_busy     [LANES]         operand 1 still pending
//   rs2_busy     [LANES]         operand 2 still pending
//
// Build option:
//   RF_WB_BYPASS_EN - when defined, an RF-selected read that hits a
//   same-cycle writeback returns the writeback data (write-first). When
//   undefined, it returns the pre-write register value. In both builds the
//   busy flag for that read is cleared by the writeback.
// -----------------------------------------------------------------------------
module regfile_fwd_multi #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      rd_en,
  input  logic [LANES*AW-1:0]   rs1_addr,
  input  logic [LANES*AW-1:0]   rs2_addr,
  input  logic [LANES*2-1:0]    rs1_fwd_sel,
  input  logic [LANES*2-1:0]    rs2_fwd_sel,
  input  logic [LANES*XLEN-1:0] rs1_ex_fwd,
  input  logic [LANES*XLEN-1:0] rs2_ex_fwd,
  input  logic [LANES*XLEN-1:0] rs1_mem_fwd,
  input  logic [LANES*XLEN-1:0] rs2_mem_fwd,
  input  logic [LANES-1:0]      issue_en,
  input  logic [LANES*AW-1:0]   issue_rd,
  input  logic [LANES-1:0]      wb_en,
  input  logic [LANES*AW-1:0]   wb_addr,
  input  logic [LANES*XLEN-1:0] wb_data,
  output logic [LANES*XLEN-1:0] rs1_data,
  output logic [LANES*XLEN-1:0] rs2_data,
  output logic [LANES-1:0]      rd_valid,
  output logic [LANES-1:0]      rs1_busy,
  output logic [LANES-1:0]      rs2_busy
);

  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // Architectural state
  logic [XLEN-1:0]       regs_q [NREG];
  logic [XLEN-1:0]       regs_d [NREG];
  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_d;

  // Registered read-port outputs
  logic [LANES*XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [LANES*XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [LANES-1:0]      rd_valid_q, rd_valid_d;
  logic [LANES-1:0]      rs1_busy_q, rs1_busy_d;
  logic [LANES-1:0]      rs2_busy_q, rs2_busy_d;

  // An address names a real, writable register: not x0 and below NREG.
  // Reads of any other address return 0 and are never busy.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  // ---------------------------------------------------------------------------
  // Writeback and issue: next register and scoreboard state
  // ---------------------------------------------------------------------------
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    // Ascending lane order makes the highest-index lane win on a collision.
    for (int i = 0; i < LANES; i++) begin
      if (wb_en[i] && addr_ok(wb_addr[i*AW +: AW])) begin
        regs_d[wb_addr[i*AW +: AW]] = wb_data[i*XLEN +: XLEN];
        busy_d[wb_addr[i*AW +: AW]] = 1'b0;
      end
    end
    // Issue is applied after writeback: a newer producer to the same
    // register keeps it pending even though an older one just completed.
    for (int i = 0; i < LANES; i++) begin
      if (issue_en[i] && addr_ok(issue_rd[i*AW +: AW])) begin
        busy_d[issue_rd[i*AW +: AW]] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: operand select, bypass and busy computation
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [AW-1:0]   a;
    logic [1:0]      sel;
    logic [XLEN-1:0] ex_val;
    logic [XLEN-1:0] mem_val;
    logic [XLEN-1:0] val;
    logic            bsy;

    a       = '0;
    sel     = '0;
    ex_val  = '0;
    mem_val = '0;
    val     = '0;
    bsy     = 1'b0;

    // Data and busy hold when a lane does not read; valid only follows rd_en.
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_busy_d = rs1_busy_q;
    rs2_busy_d = rs2_busy_q;
    rd_valid_d = rd_en;

    for (int j = 0; j < LANES; j++) begin
      if (rd_en[j]) begin
        for (int op = 0; op < 2; op++) begin
          if (op == 0) begin
            a       = rs1_addr[j*AW +: AW];
            sel     = rs1_fwd_sel[j*2 +: 2];
            ex_val  = rs1_ex_fwd[j*XLEN +: XLEN];
            mem_val = rs1_mem_fwd[j*XLEN +: XLEN];
          end else begin
            a       = rs2_addr[j*AW +: AW];
            sel     = rs2_fwd_sel[j*2 +: 2];
            ex_val  = rs2_ex_fwd[j*XLEN +: XLEN];
            mem_val = rs2_mem_fwd[j*XLEN +: XLEN];
          end

          val = '0;
          bsy = 1'b0;
          // x0 and out-of-range addresses read as zero even when a
          // forwarding path is selected.
          if (addr_ok(a)) begin
            if (sel == SEL_EX) begin
              val = ex_val;
            end else if (sel == SEL_MEM) begin
              val = mem_val;
            end else begin
              val = regs_q[a];
              bsy = busy_q[a];
              for (int k = 0; k < LANES; k++) begin
                if (wb_en[k] && (wb_addr[k*AW +: AW] == a)) begin
                  bsy = 1'b0;
`ifdef RF_WB_BYPASS_EN
                  val = wb_data[k*XLEN +: XLEN];
`endif
                end
              end
              // Intra-bundle RAW: only older (lower-index) lanes in the same
              // bundle can produce a value this lane depends on.
              for (int k = 0; k < LANES; k++) begin
                if ((k < j) && issue_en[k] && (issue_rd[k*AW +: AW] == a)) begin
                  bsy = 1'b1;
                end
              end
            end
          end

          if (op == 0) begin
            rs1_data_d[j*XLEN +: XLEN] = val;
            rs1_busy_d[j]              = bsy;
          end else begin
            rs2_data_d[j*XLEN +: XLEN] = val;
            rs2_busy_d[j]              = bsy;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rd_valid_q <= '0;
      rs1_busy_q <= '0;
      rs2_busy_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q     <= busy_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rd_valid_q <= rd_valid_d;
      rs1_busy_q <= rs1_busy_d;
      rs2_busy_q <= rs2_busy_d;
    end
  end

  assign rs1_data = rs1_data_q;
  assign rs2_data = rs2_data_q;
  assign rd_valid = rd_valid_q;
  assign rs1_busy = rs1_busy_q;
  assign rs2_busy = rs2_busy_q;

endmodule

// File: tb/tb_regfile_fwd_multi.sv
// -----------------------------------------------------------------------------
// tb_regfile_fwd_multi
//
// Self-checking bench for regfile_fwd_multi (default parameters, LANES=2).
// Directed scenarios followed by randomized traffic; every cycle's outputs are
// compared against a behavioural model of the register file and scoreboard.
// Honours RF_WB_BYPASS_EN if it is defined for the build.
// -----------------------------------------------------------------------------
module tb_regfile_fwd_multi;

  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [LANES-1:0]      rd_en;
  logic [LANES*AW-1:0]   rs1_addr, rs2_addr;
  logic [LANES*2-1:0]    rs1_fwd_sel, rs2_fwd_sel;
  logic [LANES*XLEN-1:0] rs1_ex_fwd, rs2_ex_fwd, rs1_mem_fwd, rs2_mem_fwd;
  logic [LANES-1:0]      issue_en;
  logic [LANES*AW-1:0]   issue_rd;
  logic [LANES-1:0]      wb_en;
  logic [LANES*AW-1:0]   wb_addr;
  logic [LANES*XLEN-1:0] wb_data;
  logic [LANES*XLEN-1:0] rs1_data, rs2_data;
  logic [LANES-1:0]      rd_valid, rs1_busy, rs2_busy;

  regfile_fwd_multi #(.LANES(LANES), .XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
    .rs1_ex_fwd(rs1_ex_fwd), .rs2_ex_fwd(rs2_ex_fwd),
    .rs1_mem_fwd(rs1_mem_fwd), .rs2_mem_fwd(rs2_mem_fwd),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_valid(rd_valid),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural registers, pending flags, expected outputs
  logic [XLEN-1:0] m_regs [NREG];
  logic            m_busy [NREG];
  logic [XLEN-1:0] e_d1 [LANES];
  logic [XLEN-1:0] e_d2 [LANES];
  logic            e_b1 [LANES];
  logic            e_b2 [LANES];
  logic            e_v  [LANES];

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    for (int j = 0; j < LANES; j++) begin
      e_d1[j] = '0; e_d2[j] = '0; e_b1[j] = 1'b0; e_b2[j] = 1'b0; e_v[j] = 1'b0;
    end
  endtask

  // Value and pending state seen by lane j reading address a with select s.
  task automatic model_operand(input int j, input logic [AW-1:0] a, input logic [1:0] s,
                               input logic [XLEN-1:0] ex, input logic [XLEN-1:0] mem,
                               output logic [XLEN-1:0] v, output logic b);
    logic            hit;
    logic [XLEN-1:0] hit_val;
    v = '0;
    b = 1'b0;
    hit = 1'b0;
    hit_val = '0;
    if (a == 0) return;
    if (s == 2'b01) begin
      v = ex;
    end else if (s == 2'b10) begin
      v = mem;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (wb_en[k] && wb_addr[k*AW +: AW] == a) begin
          hit = 1'b1;
          hit_val = wb_data[k*XLEN +: XLEN];
        end
      end
      v = m_regs[a];
`ifdef RF_WB_BYPASS_EN
      if (hit) v = hit_val;
`endif
      b = m_busy[a] && !hit;
      for (int k = 0; k < j; k++) begin
        if (issue_en[k] && issue_rd[k*AW +: AW] == a) b = 1'b1;
      end
    end
  endtask

  task automatic model_predict();
    for (int j = 0; j < LANES; j++) begin
      e_v[j] = rd_en[j];
      if (rd_en[j]) begin
        model_operand(j, rs1_addr[j*AW +: AW], rs1_fwd_sel[j*2 +: 2],
                      rs1_ex_fwd[j*XLEN +: XLEN], rs1_mem_fwd[j*XLEN +: XLEN], e_d1[j], e_b1[j]);
        model_operand(j, rs2_addr[j*AW +: AW], rs2_fwd_sel[j*2 +: 2],
                      rs2_ex_fwd[j*XLEN +: XLEN], rs2_mem_fwd[j*XLEN +: XLEN], e_d2[j], e_b2[j]);
      end
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < LANES; i++) begin
      if (wb_en[i] && wb_addr[i*AW +: AW] != 0) begin
        m_regs[wb_addr[i*AW +: AW]] = wb_data[i*XLEN +: XLEN];
        m_busy[wb_addr[i*AW +: AW]] = 1'b0;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (issue_en[i] && issue_rd[i*AW +: AW] != 0) m_busy[issue_rd[i*AW +: AW]] = 1'b1;
    end
  endtask

  task automatic compare_all();
    for (int j = 0; j < LANES; j++) begin
      chk($sformatf("rd_valid[%0d]", j), 32'(rd_valid[j]), 32'(e_v[j]));
      chk($sformatf("rs1_data[%0d]", j), rs1_data[j*XLEN +: XLEN], e_d1[j]);
      chk($sformatf("rs2_data[%0d]", j), rs2_data[j*XLEN +: XLEN], e_d2[j]);
      chk($sformatf("rs1_busy[%0d]", j), 32'(rs1_busy[j]), 32'(e_b1[j]));
      chk($sformatf("rs2_busy[%0d]", j), 32'(rs2_busy[j]), 32'(e_b2[j]));
    end
  endtask

  // One clock: predict from current inputs, clock, update model, check.
  task automatic cycle();
    model_predict();
    @(posedge clk);
    model_commit();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    rd_en = '0; rs1_addr = '0; rs2_addr = '0; rs1_fwd_sel = '0; rs2_fwd_sel = '0;
    rs1_ex_fwd = '0; rs2_ex_fwd = '0; rs1_mem_fwd = '0; rs2_mem_fwd = '0;
    issue_en = '0; issue_rd = '0; wb_en = '0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic set_rd(input int l, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_en[l] = 1'b1;
    rs1_addr[l*AW +: AW] = a1;
    rs2_addr[l*AW +: AW] = a2;
  endtask

  task automatic set_wb(input int l, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wb_en[l] = 1'b1;
    wb_addr[l*AW +: AW] = a;
    wb_data[l*XLEN +: XLEN] = d;
  endtask

  task automatic set_issue(input int l, input logic [AW-1:0] a);
    issue_en[l] = 1'b1;
    issue_rd[l*AW +: AW] = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Reset then read
    clear_inputs();
    set_rd(0, 5'd1, 5'd1); set_rd(1, 5'd1, 5'd1);
    cycle();
    chk("reset_read_data", rs1_data[0 +: XLEN], 32'h0);
    chk("reset_read_valid", 32'(rd_valid), 32'h3);

    // Write then read, and x0 writes ignored
    clear_inputs(); set_wb(0, 5'd1, 32'h0000_0123); cycle();
    clear_inputs(); set_rd(1, 5'd1, 5'd0); cycle();
    chk("wr_rd_x1", rs1_data[XLEN +: XLEN], 32'h0000_0123);
    clear_inputs(); set_wb(0, 5'd0, 32'hFFFF_FFFF); cycle();
    clear_inputs(); set_rd(0, 5'd0, 5'd0); rs2_fwd_sel[1:0] = 2'b01; rs2_ex_fwd[0 +: XLEN] = 32'h1234_5678;
    cycle();
    chk("x0_read", rs1_data[0 +: XLEN], 32'h0);
    chk("x0_fwd_read", rs2_data[0 +: XLEN], 32'h0);

    // Forwarding of pending registers reports not busy
    clear_inputs(); set_issue(0, 5'd7); set_issue(1, 5'd8); cycle();
    clear_inputs(); set_rd(0, 5'd7, 5'd8);
    rs1_fwd_sel[1:0] = 2'b01; rs1_ex_fwd[0 +: XLEN] = 32'hDEAD_BEEF;
    rs2_fwd_sel[1:0] = 2'b10; rs2_mem_fwd[0 +: XLEN] = 32'h0000_0006;
    cycle();
    chk("fwd_ex", rs1_data[0 +: XLEN], 32'hDEAD_BEEF);
    chk("fwd_mem", rs2_data[0 +: XLEN], 32'h0000_0006);
    chk("fwd_busy", {30'b0, rs2_busy[0], rs1_busy[0]}, 32'h0);

    // Scoreboard: younger lane issue does not affect older lane
    clear_inputs(); set_issue(1, 5'd3); set_rd(0, 5'd3, 5'd0); cycle();
    chk("younger_issue_busy", 32'(rs1_busy[0]), 32'h0);
    clear_inputs(); set_wb(0, 5'd3, 32'h0); cycle();
    // Older lane issue makes younger lane operand busy
    clear_inputs(); set_issue(0, 5'd3); set_rd(1, 5'd3, 5'd0); cycle();
    chk("bundle_raw_busy", 32'(rs1_busy[1]), 32'h1);
    clear_inputs(); set_rd(0, 5'd3, 5'd3); cycle();
    chk("pending_busy", 32'(rs1_busy[0]), 32'h1);
    clear_inputs(); set_wb(1, 5'd3, 32'h0000_0007); cycle();
    clear_inputs(); set_rd(0, 5'd3, 5'd0); cycle();
    chk("after_wb_data", rs1_data[0 +: XLEN], 32'h7);
    chk("after_wb_busy", 32'(rs1_busy[0]), 32'h0);

    // Same-cycle writeback and read; same-address multi-lane writeback
    clear_inputs(); set_wb(0, 5'd5, 32'h44); cycle();
    clear_inputs(); set_wb(0, 5'd5, 32'h55); set_rd(1, 5'd5, 5'd0); cycle();
`ifdef RF_WB_BYPASS_EN
    chk("wb_same_cycle", rs1_data[XLEN +: XLEN], 32'h55);
`else
    chk("wb_same_cycle", rs1_data[XLEN +: XLEN], 32'h44);
`endif
    clear_inputs(); set_wb(0, 5'd5, 32'h11); set_wb(1, 5'd5, 32'h22); cycle();
    clear_inputs(); set_rd(0, 5'd5, 5'd5); cycle();
    chk("wb_lane_prio", rs1_data[0 +: XLEN], 32'h22);

    // Issue and writeback to the same register: stays busy
    clear_inputs(); set_issue(0, 5'd9); set_wb(1, 5'd9, 32'h99); cycle();
    clear_inputs(); set_rd(0, 5'd9, 5'd0); cycle();
    chk("issue_beats_wb", 32'(rs1_busy[0]), 32'h1);

    // Asynchronous reset mid-operation
    clear_inputs(); set_wb(0, 5'd4, 32'h9); cycle();
    clear_inputs(); set_issue(0, 5'd4); set_rd(1, 5'd4, 5'd0); cycle();
    clear_inputs(); set_rd(0, 5'd4, 5'd4); cycle();
    chk("pre_reset_data", rs1_data[0 +: XLEN], 32'h9);
    clear_inputs(); set_wb(0, 5'd4, 32'hAB); set_issue(1, 5'd6); set_rd(0, 5'd4, 5'd6);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_valid", 32'(rd_valid), 32'h0);
    chk("async_rst_data", rs1_data[0 +: XLEN], 32'h0);
    chk("async_rst_busy", {30'b0, rs1_busy[1], rs1_busy[0]}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    clear_inputs(); set_rd(0, 5'd4, 5'd6); cycle();
    chk("post_rst_x4", rs1_data[0 +: XLEN], 32'h0);
    chk("post_rst_busy", {30'b0, rs2_busy[0], rs1_busy[0]}, 32'h0);

    // Randomized traffic on a small address window to force collisions
    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      for (int l = 0; l < LANES; l++) begin
        rd_en[l] = ($urandom_range(0, 3) != 0);
        rs1_addr[l*AW +: AW] = AW'($urandom_range(0, 7));
        rs2_addr[l*AW +: AW] = AW'($urandom_range(0, 7));
        rs1_fwd_sel[l*2 +: 2] = 2'($urandom_range(0, 3));
        rs2_fwd_sel[l*2 +: 2] = 2'($urandom_range(0, 3));
        rs1_ex_fwd[l*XLEN +: XLEN] = $urandom;
        rs2_ex_fwd[l*XLEN +: XLEN] = $urandom;
        rs1_mem_fwd[l*XLEN +: XLEN] = $urandom;
        rs2_mem_fwd[l*XLEN +: XLEN] = $urandom;
        issue_en[l] = ($urandom_range(0, 2) == 0);
        issue_rd[l*AW +: AW] = AW'($urandom_range(0, 7));
        wb_en[l] = ($urandom_range(0, 1) == 0);
        wb_addr[l*AW +: AW] = AW'($urandom_range(0, 7));
        wb_data[l*XLEN +: XLEN] = $urandom;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
